// File: rtl/hcordic_pkg.sv
// Shared state type and elaboration-time constants for the hyperbolic CORDIC.
// HCORDIC_GAIN_COMP_EN adds the GAIN state.
package hcordic_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ROTATE = 2'd1,
`ifdef HCORDIC_GAIN_COMP_EN
    ST_GAIN   = 2'd2,
`endif
    ST_DONE   = 2'd3
  } state_t;

  // Hyperbolic CORDIC only converges if these shifts are executed twice.
  function automatic bit is_repeat(input int i, input int iter);
    return (i == 4) || (i == 13) || ((i == 40) && (iter >= 40));
  endfunction

  function automatic int num_rot(input int iter);
    int n;
    n = iter;
    for (int k = 1; k <= iter; k++) begin
      if (is_repeat(k, iter)) n++;
    end
    return n;
  endfunction

  function automatic real pow2_neg(input int i);
    real t;
    t = 1.0;
    for (int k = 0; k < i; k++) t = t / 2.0;
    return t;
  endfunction

  // Real-to-integer cast rounds to nearest.
  function automatic longint to_fixed(input real v, input int fw);
    return longint'(v / pow2_neg(fw));
  endfunction

  // atanh(t) = t + t^3/3 + t^5/5 + ..., t = 2^-i.
  function automatic longint atanh_fixed(input int i, input int fw);
    real t, p, s;
    if (i <= 0) return 64'sd0;
    t = pow2_neg(i);
    p = t;
    s = 0.0;
    for (int n = 1; n < 80; n += 2) begin
      s = s + p / real'(n);
      p = p * t * t;
    end
    return to_fixed(s, fw);
  endfunction

  // 1/K_h as a fixed-point word; each set bit b is one term x >>> (fw - b).
  function automatic longint invk_terms(input int fw, input int iter);
    real k, f, t;
    k = 1.0;
    for (int i = 1; i <= iter; i++) begin
      t = pow2_neg(i);
      f = $sqrt(1.0 - t * t);
      k = k * f;
      if (is_repeat(i, iter)) k = k * f;
    end
    return to_fixed(1.0 / k, fw);
  endfunction

endpackage

// File: rtl/hcordic_microrot.sv
// One combinational hyperbolic micro-rotation at shift i.
// The atanh(2^-i) table is fixed at elaboration.
module hcordic_microrot
  import hcordic_pkg::*;
#(
  parameter int DWIDTH    = 21,
  parameter int FRA_WIDTH = 16,
  parameter int IW        = 5
) (
  input  logic signed [DWIDTH-1:0] x,
  input  logic signed [DWIDTH-1:0] y,
  input  logic signed [DWIDTH-1:0] z,
  input  logic        [IW-1:0]     i,
  input  logic                     mode,
  output logic signed [DWIDTH-1:0] x_next,
  output logic signed [DWIDTH-1:0] y_next,
  output logic signed [DWIDTH-1:0] z_next
);

  logic signed [DWIDTH-1:0] atanh_tab [2**IW];

  for (genvar k = 0; k < 2**IW; k++) begin : g_tab
    localparam logic signed [DWIDTH-1:0] C = DWIDTH'(atanh_fixed(k, FRA_WIDTH));
    assign atanh_tab[k] = C;
  end

  logic signed [DWIDTH-1:0] xs, ys, at;
  logic                     d_pos;

  always_comb begin
    xs    = x >>> i;
    ys    = y >>> i;
    at    = atanh_tab[i];
    d_pos = mode ? y[DWIDTH-1] : ~z[DWIDTH-1];
    if (d_pos) begin
      x_next = x + ys;
      y_next = y + xs;
      z_next = z - at;
    end else begin
      x_next = x - ys;
      y_next = y - xs;
      z_next = z + at;
    end
  end

endmodule

// File: rtl/hcordic_iter.sv
// Iterative hyperbolic CORDIC, one micro-rotation per cycle, result held until accepted.
// HCORDIC_GAIN_COMP_EN adds a one-cycle GAIN state that scales x and y by 1/K_h.
module hcordic_iter
  import hcordic_pkg::*;
#(
  parameter int INT_WIDTH = 4,
  parameter int FRA_WIDTH = 16,
  parameter int DWIDTH    = 1 + INT_WIDTH + FRA_WIDTH,
  parameter int ITER      = 16
) (
  input  logic                     iClk,
  input  logic                     iRst,
  input  logic                     iValid,
  output logic                     oReady,
  input  logic                     iMode,
  input  logic signed [DWIDTH-1:0] iX,
  input  logic signed [DWIDTH-1:0] iY,
  input  logic signed [DWIDTH-1:0] iZ,
  output logic                     oValid,
  input  logic                     iReady,
  output logic signed [DWIDTH-1:0] oX,
  output logic signed [DWIDTH-1:0] oY,
  output logic signed [DWIDTH-1:0] oZ
);

  localparam int IW = $clog2(ITER + 2);
  localparam logic [IW-1:0] I_LAST = IW'(ITER);

  state_t                   state, state_next;
  logic signed [DWIDTH-1:0] x, y, z, x_rot, y_rot, z_rot;
  logic                     mode, rep, rep_here, last_rot;
  logic [IW-1:0]            i;

  assign rep_here = is_repeat(int'(i), ITER);
  assign last_rot = (i == I_LAST) && (!rep_here || rep);

  hcordic_microrot #(
    .DWIDTH(DWIDTH), .FRA_WIDTH(FRA_WIDTH), .IW(IW)
  ) u_microrot (
    .x(x), .y(y), .z(z), .i(i), .mode(mode),
    .x_next(x_rot), .y_next(y_rot), .z_next(z_rot)
  );

`ifdef HCORDIC_GAIN_COMP_EN
  localparam logic [FRA_WIDTH:0] INVK = (FRA_WIDTH+1)'(invk_terms(FRA_WIDTH, ITER));
  logic signed [DWIDTH-1:0] x_gain, y_gain;

  always_comb begin
    x_gain = '0;
    y_gain = '0;
    for (int b = 0; b <= FRA_WIDTH; b++) begin
      if (INVK[b]) begin
        x_gain = x_gain + (x >>> (FRA_WIDTH - b));
        y_gain = y_gain + (y >>> (FRA_WIDTH - b));
      end
    end
  end
`endif

  always_ff @(posedge iClk or posedge iRst) begin
    if (iRst) state <= ST_IDLE;
    else      state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      ST_IDLE:   if (iValid) state_next = ST_ROTATE;
`ifdef HCORDIC_GAIN_COMP_EN
      ST_ROTATE: if (last_rot) state_next = ST_GAIN;
      ST_GAIN:   state_next = ST_DONE;
`else
      ST_ROTATE: if (last_rot) state_next = ST_DONE;
`endif
      ST_DONE:   if (iReady) state_next = ST_IDLE;
      default:   state_next = ST_IDLE;
    endcase
  end

  always_comb begin
    oReady = (state == ST_IDLE);
    oValid = (state == ST_DONE);
    oX     = x;
    oY     = y;
    oZ     = z;
  end

  always_ff @(posedge iClk or posedge iRst) begin
    if (iRst) begin
      x    <= '0;
      y    <= '0;
      z    <= '0;
      mode <= 1'b0;
      i    <= IW'(1);
      rep  <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (iValid) begin
            x    <= iX;
            y    <= iY;
            z    <= iZ;
            mode <= iMode;
            i    <= IW'(1);
            rep  <= 1'b0;
          end
        end
        ST_ROTATE: begin
          x <= x_rot;
          y <= y_rot;
          z <= z_rot;
          // First pass of a repeat index keeps i and arms the second pass.
          if (rep_here && !rep) begin
            rep <= 1'b1;
          end else begin
            rep <= 1'b0;
            i   <= i + IW'(1);
          end
        end
`ifdef HCORDIC_GAIN_COMP_EN
        ST_GAIN: begin
          x <= x_gain;
          y <= y_gain;
        end
`endif
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_hcordic_iter.sv
// Self-checking bench for hcordic_iter: randomized operations against a schedule-level model.
`timescale 1ns/1ps
module tb_hcordic_iter;
  localparam int  FRA  = 16;
  localparam int  DW   = 21;
  localparam int  ITER = 16;
  localparam real SCALE = 65536.0;
  localparam real TOL   = 1.0 / 4096.0;
`ifdef HCORDIC_GAIN_COMP_EN
  localparam int LAT  = 19;
  localparam bit GAIN = 1'b1;
`else
  localparam int LAT  = 18;
  localparam bit GAIN = 1'b0;
`endif

  typedef struct {
    longint x, y, z;
    int     acc;
    int     lit;
  } exp_t;

  logic iClk, iRst, iValid, oReady, iMode, oValid, iReady;
  logic signed [DW-1:0] iX, iY, iZ, oX, oY, oZ;

  hcordic_iter #(.INT_WIDTH(4), .FRA_WIDTH(FRA), .DWIDTH(DW), .ITER(ITER)) dut (
    .iClk(iClk), .iRst(iRst), .iValid(iValid), .oReady(oReady), .iMode(iMode),
    .iX(iX), .iY(iY), .iZ(iZ), .oValid(oValid), .iReady(iReady),
    .oX(oX), .oY(oY), .oZ(oZ)
  );

  initial iClk = 1'b0;
  always #5 iClk = ~iClk;

  // ---------------- reference model ----------------
  function automatic longint wrap(input longint v);
    return (v <<< (64 - DW)) >>> (64 - DW);
  endfunction

  function automatic longint atanh_ref(input int i);
    real t;
    t = 1.0;
    for (int k = 0; k < i; k++) t = t / 2.0;
    return longint'(0.5 * $ln((1.0 + t) / (1.0 - t)) * SCALE);
  endfunction

  function automatic exp_t model(input bit m, input longint x0, input longint y0, input longint z0);
    int     sched[$];
    exp_t   e;
    longint x, y, z, xs, ys;
    int     s;
    x = x0; y = y0; z = z0;
    for (int i = 1; i <= ITER; i++) begin
      sched.push_back(i);
      if (i == 4 || i == 13 || i == 40) sched.push_back(i);
    end
    foreach (sched[k]) begin
      s  = sched[k];
      xs = x >>> s;
      ys = y >>> s;
      if ((!m && z >= 0) || (m && y < 0)) begin
        x = wrap(x + ys); y = wrap(y + xs); z = wrap(z - atanh_ref(s));
      end else begin
        x = wrap(x - ys); y = wrap(y - xs); z = wrap(z + atanh_ref(s));
      end
    end
    if (GAIN) begin
      real    kh, t;
      longint c, gx, gy;
      kh = 1.0;
      foreach (sched[k]) begin
        t  = 1.0;
        for (int n = 0; n < sched[k]; n++) t = t / 2.0;
        kh = kh * $sqrt(1.0 - t * t);
      end
      c  = longint'(SCALE / kh);
      gx = 0; gy = 0;
      for (int b = 0; b <= FRA; b++) begin
        if (c[b]) begin
          gx = gx + (x >>> (FRA - b));
          gy = gy + (y >>> (FRA - b));
        end
      end
      x = wrap(gx); y = wrap(gy);
    end
    e.x = x; e.y = y; e.z = z; e.acc = 0; e.lit = 0;
    return e;
  endfunction

  // ---------------- checking ----------------
  int   n_chk = 0, n_pass = 0, ncyc = 0, timeouts = 0, lit_sel = 0, rdy_mode = 0;
  bit   finishing = 1'b0, final_done = 1'b0;
  exp_t q[$];

  task automatic chk(input string name, input longint act, input longint exp);
    n_chk++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, ncyc);
  endtask

  task automatic chk_tol(input string name, input real act, input real exp);
    real d;
    d = act - exp;
    if (d < 0.0) d = -d;
    n_chk++;
    if (d <= TOL) n_pass++;
    else $display("FAIL %s: got %f, expected %f", name, act, exp);
  endtask

  task automatic lit_check(input exp_t e);
    real ex, ey, ez;
    if (e.lit == 1) begin
      ex = GAIN ? 1.12763 : 0.93385; ey = GAIN ? 0.52110 : 0.43158; ez = 0.0;
    end else begin
      ex = GAIN ? 0.86603 : 0.71721; ey = 0.0; ez = 0.54931;
    end
    chk_tol("lit_oX", real'(longint'(oX)) / SCALE, ex);
    chk_tol("lit_oY", real'(longint'(oY)) / SCALE, ey);
    chk_tol("lit_oZ", real'(longint'(oZ)) / SCALE, ez);
    chk_tol("model_x", real'(e.x) / SCALE, ex);
    chk_tol("model_z", real'(e.z) / SCALE, ez);
  endtask

  initial begin : monitor
    bit   busy, exp_vld;
    exp_t e;
    forever begin
      @(negedge iClk);
      if (finishing && !final_done) begin
        chk("drained", longint'(q.size()), 0);
        chk("timeouts", longint'(timeouts), 0);
        final_done = 1'b1;
      end
      if (iRst) begin
        chk("rst_ready", longint'(oReady), 1);
        chk("rst_valid", longint'(oValid), 0);
        chk("rst_oX", longint'(oX), 0);
        chk("rst_oY", longint'(oY), 0);
        chk("rst_oZ", longint'(oZ), 0);
        q.delete();
      end else begin
        busy    = (q.size() != 0);
        exp_vld = busy && (ncyc - q[0].acc > LAT);
        chk("ready", longint'(oReady), longint'(!busy));
        chk("valid", longint'(oValid), longint'(exp_vld));
        if (exp_vld) begin
          chk("oX", longint'(oX), q[0].x);
          chk("oY", longint'(oY), q[0].y);
          chk("oZ", longint'(oZ), q[0].z);
          if (q[0].lit != 0 && ncyc - q[0].acc == LAT + 1) lit_check(q[0]);
          if (iReady) void'(q.pop_front());
        end else if (!busy && iValid) begin
          e = model(iMode, longint'(iX), longint'(iY), longint'(iZ));
          e.acc = ncyc;
          e.lit = lit_sel;
          q.push_back(e);
        end
      end
      ncyc++;
    end
  end

  // ---------------- stimulus ----------------
  initial begin : ready_drv
    iReady = 1'b1;
    forever begin
      @(posedge iClk); #1;
      case (rdy_mode)
        0:       iReady = 1'b1;
        1:       iReady = 1'($urandom_range(0, 1));
        default: iReady = 1'b0;
      endcase
    end
  end

  task automatic wait_ready();
    bit ok;
    ok = 1'b0;
    for (int k = 0; k < 300 && !ok; k++) begin
      @(negedge iClk);
      ok = oReady;
    end
    if (!ok) timeouts++;
  endtask

  task automatic wait_valid();
    bit ok;
    ok = 1'b0;
    for (int k = 0; k < 300 && !ok; k++) begin
      @(negedge iClk);
      ok = oValid;
    end
    if (!ok) timeouts++;
  endtask

  task automatic send(input bit m, input longint x, input longint y, input longint z,
                      input int lit, input bit keep);
    iMode = m; iX = DW'(x); iY = DW'(y); iZ = DW'(z); lit_sel = lit; iValid = 1'b1;
    wait_ready();
    @(posedge iClk); #1;
    if (!keep) iValid = 1'b0;
  endtask

  task automatic idle_wait();
    wait_ready();
    @(posedge iClk); #1;
  endtask

  initial begin : stim
    int x, y, z, lim;
    iRst = 1'b1; iValid = 1'b0; iMode = 1'b0; iX = '0; iY = '0; iZ = '0;
    repeat (3) @(posedge iClk);
    #1 iRst = 1'b0;

    send(1'b0, 65536, 0, 32768, 1, 1'b0);
    idle_wait();
    send(1'b1, 65536, 32768, 0, 2, 1'b0);
    idle_wait();

    // Result held under backpressure while a new request is ignored.
    rdy_mode = 2;
    send(1'b0, 50000, -20000, -40000, 0, 1'b0);
    wait_valid();
    @(posedge iClk); #1;
    iMode = 1'b1; iX = 21'sd70000; iY = 21'sd1000; iZ = 21'sd5; iValid = 1'b1;
    repeat (5) @(posedge iClk);
    #1 iValid = 1'b0;
    rdy_mode = 0;
    idle_wait();

    // Reset in the middle of ROTATE discards the operation.
    send(1'b0, 40000, 30000, 60000, 0, 1'b0);
    repeat (7) @(posedge iClk);
    #1 iRst = 1'b1;
    repeat (2) @(posedge iClk);
    #1 iRst = 1'b0;
    send(1'b0, 65536, 0, 32768, 1, 1'b0);
    idle_wait();

    // Back-to-back with iValid held high.
    send(1'b0, 65536, 0, 32768, 1, 1'b1);
    send(1'b1, 65536, 32768, 0, 2, 1'b0);
    idle_wait();

    rdy_mode = 1;
    for (int n = 0; n < 30; n++) begin
      if ($urandom_range(0, 1) == 0) begin
        x = int'($urandom_range(0, 131072)) - 65536;
        y = int'($urandom_range(0, 131072)) - 65536;
        z = int'($urandom_range(0, 144000)) - 72000;
        send(1'b0, x, y, z, 0, 1'($urandom_range(0, 1)));
      end else begin
        x   = int'($urandom_range(20000, 131072));
        lim = x * 8 / 10;
        y   = int'($urandom_range(0, 2 * lim)) - lim;
        send(1'b1, x, y, 0, 0, 1'($urandom_range(0, 1)));
      end
    end
    // Out-of-range operands still terminate with wrapped results.
    for (int n = 0; n < 4; n++) begin
      send(1'(n), longint'($urandom_range(0, 2097151)), longint'($urandom_range(0, 2097151)),
           longint'($urandom_range(0, 2097151)), 0, 1'b0);
    end
    iValid = 1'b0;
    idle_wait();
    rdy_mode = 0;
    idle_wait();

    finishing = 1'b1;
    repeat (2) @(negedge iClk);
    #1;
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
